// File: rtl/id_scan_pkg.sv
// id_scan_pkg -- shared encodings for the identifier scanner.
//   ctrl_state_e : control FSM states (IDLE, RUN, FLUSH, DONE)
//   cls_state_e  : token class FSM states (NONE, ALPHA, NUM)
//   char_class_e : per-character class codes (OTHER, LETTER, DIGIT)
//   ASCII_*      : inclusive bounds of the letter and digit ranges
//   in_range()   : inclusive range test on an 8-bit character
package id_scan_pkg;

    typedef enum logic [1:0] {
        CTRL_IDLE  = 2'd0,
        CTRL_RUN   = 2'd1,
        CTRL_FLUSH = 2'd2,
        CTRL_DONE  = 2'd3
    } ctrl_state_e;

    typedef enum logic [1:0] {
        CLS_NONE  = 2'd0,
        CLS_ALPHA = 2'd1,
        CLS_NUM   = 2'd2
    } cls_state_e;

    typedef enum logic [1:0] {
        CC_OTHER  = 2'd0,
        CC_LETTER = 2'd1,
        CC_DIGIT  = 2'd2
    } char_class_e;

    localparam logic [7:0] ASCII_UC_A = 8'h41;
    localparam logic [7:0] ASCII_UC_Z = 8'h5A;
    localparam logic [7:0] ASCII_LC_A = 8'h61;
    localparam logic [7:0] ASCII_LC_Z = 8'h7A;
    localparam logic [7:0] ASCII_D0   = 8'h30;
    localparam logic [7:0] ASCII_D9   = 8'h39;

    function automatic logic in_range(input logic [7:0] c,
                                      input logic [7:0] lo,
                                      input logic [7:0] hi);
        return (c >= lo) && (c <= hi);
    endfunction

endpackage

// File: rtl/id_char_class.sv
// id_char_class -- combinational ASCII character classifier.
//   char_i  [7:0] : ASCII character
//   class_o       : CC_LETTER for A-Z / a-z, CC_DIGIT for 0-9, CC_OTHER otherwise
module id_char_class
    import id_scan_pkg::*;
(
    input  logic [7:0]  char_i,
    output char_class_e class_o
);

    always_comb begin
        class_o = CC_OTHER;
        if (in_range(char_i, ASCII_UC_A, ASCII_UC_Z) ||
            in_range(char_i, ASCII_LC_A, ASCII_LC_Z)) begin
            class_o = CC_LETTER;
        end else if (in_range(char_i, ASCII_D0, ASCII_D9)) begin
            class_o = CC_DIGIT;
        end
    end

endmodule

// File: rtl/id_scan_ctrl.sv
// id_scan_ctrl -- scans an ASCII stream for identifier tokens: a letter,
// followed by letters/digits, containing at least one digit at its end
// position when terminated (class state NUM). Reports each token length.
//
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   start                  : begin a stream (ignored unless idle)
//   char_valid/char_i/char_last : character input; char_i carries the
//                            character (the bare name "char" is a reserved word)
//   char_ready             : high while streaming (RUN)
//   tok_valid/tok_len      : one-cycle token pulse and its length (held otherwise)
//   busy, done             : not idle / one-cycle end-of-stream pulse
//   id_count               : tokens found in the current stream
//
// Configuration: define ID_SCAN_STATS_EN to build the id_count counter;
// otherwise id_count is tied to zero.
module id_scan_ctrl
    import id_scan_pkg::*;
#(
    parameter int LEN_W = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             char_valid,
    input  logic [7:0]       char_i,
    input  logic             char_last,
    output logic             char_ready,
    output logic             tok_valid,
    output logic [LEN_W-1:0] tok_len,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] id_count
);

    localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

    ctrl_state_e      ctrl_q;
    cls_state_e       cls_q, cls_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             tok_valid_q;
    logic [LEN_W-1:0] tok_len_q;
    logic             ready_q, busy_q, done_q;
    char_class_e      cc;
    logic             consume;
    logic             emit_other;
    logic             emit_last;

    id_char_class u_class (
        .char_i  (char_i),
        .class_o (cc)
    );

    assign consume = char_valid && ready_q;

    // Class FSM and length counter next state for the character on the bus.
    always_comb begin
        cls_d = cls_q;
        len_d = len_q;
        unique case (cc)
            CC_LETTER: cls_d = CLS_ALPHA;
            CC_DIGIT:  cls_d = (cls_q == CLS_NONE) ? CLS_NONE : CLS_NUM;
            default:   cls_d = CLS_NONE;
        endcase
        if (cc == CC_LETTER && cls_q == CLS_NONE) begin
            len_d = LEN_W'(1);
        end else if (cc != CC_OTHER && cls_q != CLS_NONE && len_q != LEN_MAX) begin
            len_d = len_q + LEN_W'(1);
        end
    end

    // A separator after a NUM token emits on the next cycle. A token still
    // open (NUM) after the last character is emitted during FLUSH; because
    // tok_valid is registered, that decision is taken as the last character
    // is consumed. The two cases are exclusive, so a separator that is also
    // the last character yields exactly one pulse.
    assign emit_other = consume && (cc == CC_OTHER) && (cls_q == CLS_NUM);
    assign emit_last  = consume && char_last && (cls_d == CLS_NUM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q      <= CTRL_IDLE;
            cls_q       <= CLS_NONE;
            len_q       <= '0;
            tok_valid_q <= 1'b0;
            tok_len_q   <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            tok_valid_q <= 1'b0;
            done_q      <= 1'b0;
            unique case (ctrl_q)
                CTRL_IDLE: begin
                    if (start) begin
                        ctrl_q  <= CTRL_RUN;
                        cls_q   <= CLS_NONE;
                        len_q   <= '0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                CTRL_RUN: begin
                    if (consume) begin
                        cls_q <= cls_d;
                        len_q <= len_d;
                        if (emit_other) begin
                            tok_valid_q <= 1'b1;
                            tok_len_q   <= len_q;
                        end else if (emit_last) begin
                            tok_valid_q <= 1'b1;
                            tok_len_q   <= len_d;
                        end
                        if (char_last) begin
                            ctrl_q  <= CTRL_FLUSH;
                            ready_q <= 1'b0;
                        end
                    end
                end
                CTRL_FLUSH: begin
                    ctrl_q <= CTRL_DONE;
                    done_q <= 1'b1;
                end
                default: begin
                    ctrl_q <= CTRL_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign char_ready = ready_q;
    assign tok_valid  = tok_valid_q;
    assign tok_len    = tok_len_q;
    assign busy       = busy_q;
    assign done       = done_q;

`ifdef ID_SCAN_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    logic [CNT_W-1:0] id_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_count_q <= '0;
        end else if (ctrl_q == CTRL_IDLE && start) begin
            id_count_q <= '0;
        end else if (tok_valid_q && id_count_q != CNT_MAX) begin
            id_count_q <= id_count_q + CNT_W'(1);
        end
    end

    assign id_count = id_count_q;
`else
    assign id_count = '0;
`endif

endmodule

// File: tb/tb_id_scan_ctrl.sv
// tb_id_scan_ctrl -- directed, scoreboarded bench for id_scan_ctrl.
// Expected token lengths are queued before each stream and popped as
// tok_valid pulses arrive.
module tb_id_scan_ctrl;

    localparam int LEN_W = 5;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             char_valid;
    logic [7:0]       char_i;
    logic             char_last;
    logic             char_ready;
    logic             tok_valid;
    logic [LEN_W-1:0] tok_len;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] id_count;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int last_len = 0;

    id_scan_ctrl #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .char_valid (char_valid),
        .char_i     (char_i),
        .char_last  (char_last),
        .char_ready (char_ready),
        .tok_valid  (tok_valid),
        .tok_len    (tok_len),
        .busy       (busy),
        .done       (done),
        .id_count   (id_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_ids(input int n);
`ifdef ID_SCAN_STATS_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Feed one stream; tokens are compared against exp_q as they appear.
    task automatic run_stream(input string s, input bit toggle, input bit hold_start, input int n_ids);
        int  idx = 0;
        int  cyc = 0;
        int  dones = 0;
        int  tok_cyc = -1;
        int  done_cyc = -1;
        bit  phase = 1'b1;
        bit  consumed;
        int  e;
        start = 1'b1;
        @(posedge clk); #1;
        start = hold_start;
        check("busy_after_start", 32'(busy), 32'd1);
        while (dones == 0 && cyc < 500) begin
            if (idx < s.len()) begin
                char_valid = toggle ? phase : 1'b1;
                char_i     = s[idx];
                char_last  = (idx == s.len() - 1);
                phase      = ~phase;
            end else begin
                char_valid = 1'b0;
                char_i     = 8'h00;
                char_last  = 1'b0;
            end
            consumed = char_valid && char_ready;
            @(posedge clk); #1;
            cyc++;
            if (consumed) idx++;
            if (tok_valid) begin
                if (exp_q.size() == 0) begin
                    check("extra_tok", 32'(tok_len), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("tok_len", 32'(tok_len), 32'(e));
                    last_len = e;
                end
                tok_cyc = cyc;
            end else begin
                check("tok_len_hold", 32'(tok_len), 32'(last_len));
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
        end
        start      = 1'b0;
        char_valid = 1'b0;
        char_last  = 1'b0;
        $display("stream \"%s\" consumed=%0d cycles=%0d dones=%0d", s, idx, cyc, dones);
        check("done_seen", 32'(dones), 32'd1);
        check("all_chars_consumed", 32'(idx), 32'(s.len()));
        check("tok_queue_empty", 32'(exp_q.size()), 32'd0);
        if (tok_cyc >= 0) check("done_after_tok", 32'(done_cyc - tok_cyc), 32'd1);
        @(posedge clk); #1;
        check("done_single_pulse", 32'(done), 32'd0);
        check("tok_after_done", 32'(tok_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ready", 32'(char_ready), 32'd0);
        check("id_count", 32'(id_count), 32'(exp_ids(n_ids)));
        exp_q.delete();
    endtask

    initial begin
        string sat;
        int    fed;
        rst_n      = 1'b0;
        start      = 1'b0;
        char_valid = 1'b0;
        char_i     = 8'h00;
        char_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(char_ready), 32'd0);
        check("rst_tok_valid", 32'(tok_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_tok_len", 32'(tok_len), 32'd0);
        check("rst_id_count", 32'(id_count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // "ab12 " with start held high throughout: start must be ignored.
        exp_q.push_back(4);
        run_stream("ab12 ", 1'b0, 1'b1, 1);

        // Token closed by the last character itself: emitted in FLUSH.
        exp_q.push_back(2);
        run_stream("x9", 1'b0, 1'b0, 1);

        // Digits without a leading letter and letter-only words: no tokens.
        run_stream("123 abc ;", 1'b0, 1'b1, 0);

        // Gapped valid.
        exp_q.push_back(2);
        exp_q.push_back(4);
        run_stream("a1 b2c3 ", 1'b1, 1'b0, 2);

        // Length saturation at 31.
        sat = "a";
        for (int i = 0; i < 40; i++) sat = {sat, "1"};
        sat = {sat, " "};
        exp_q.push_back(31);
        run_stream(sat, 1'b0, 1'b0, 1);

        // Reset mid-stream after "ab1" has been consumed.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        fed = 0;
        for (int c = 0; c < 20 && fed < 3; c++) begin
            char_valid = 1'b1;
            char_last  = 1'b0;
            char_i     = (fed == 0) ? 8'h61 : (fed == 1) ? 8'h62 : 8'h31;
            if (char_ready) fed++;
            @(posedge clk); #1;
        end
        char_valid = 1'b0;
        check("mid_fed", 32'(fed), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        $display("mid-stream reset asserted");
        check("mrst_ready", 32'(char_ready), 32'd0);
        check("mrst_tok_valid", 32'(tok_valid), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_tok_len", 32'(tok_len), 32'd0);
        check("mrst_id_count", 32'(id_count), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        last_len = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("post_rst_tok_valid", 32'(tok_valid), 32'd0);
            check("post_rst_done", 32'(done), 32'd0);
            check("post_rst_busy", 32'(busy), 32'd0);
        end

        exp_q.push_back(2);
        run_stream("q7 ", 1'b0, 1'b0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
